// File: rtl/cache_pkg.sv
// Shared types and address helpers for the 2-way read-only cache controller.
// Addresses are word addresses laid out as {tag, set}.
package cache_pkg;

    localparam int TAG_WIDTH_DEF  = 13;
    localparam int DATA_WIDTH_DEF = 16;
    localparam int SET_WIDTH_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        MISS_REQ,
        MISS_WAIT
    } ctrl_state_t;

    function automatic logic [31:0] addr_set(input logic [31:0] addr, input int set_w);
        return addr & ((32'd1 << set_w) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int set_w);
        return addr >> set_w;
    endfunction

endpackage

// File: rtl/cache_set_state.sv
// Per-set valid bits for both ways plus one LRU bit (the way to evict next).
// Reads are combinational; clear_all invalidates every line but keeps LRU history.
module cache_set_state #(
    parameter int SET_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 clear_all,
    input  logic [SET_WIDTH-1:0] rd_set,
    output logic                 rd_valid0,
    output logic                 rd_valid1,
    output logic                 rd_lru,
    input  logic                 upd_en,
    input  logic [SET_WIDTH-1:0] upd_set,
    input  logic                 fill_en,
    input  logic                 fill_way,
    input  logic                 lru_way
);

    localparam int NSETS = 1 << SET_WIDTH;

    logic [NSETS-1:0] valid0;
    logic [NSETS-1:0] valid1;
    logic [NSETS-1:0] lru;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid0 <= '0;
            valid1 <= '0;
            lru    <= '0;
        end else if (clear_all) begin
            valid0 <= '0;
            valid1 <= '0;
        end else if (upd_en) begin
            lru[upd_set] <= lru_way;
            if (fill_en && !fill_way) valid0[upd_set] <= 1'b1;
            if (fill_en &&  fill_way) valid1[upd_set] <= 1'b1;
        end
    end

    assign rd_valid0 = valid0[rd_set];
    assign rd_valid1 = valid1[rd_set];
    assign rd_lru    = lru[rd_set];

endmodule

// File: rtl/cache_ctrl_2way.sv
// Read controller for two cache_way BRAMs: lookup, victim choice, memory fill.
// Hits answer 2 cycles after acceptance; misses hold the memory request until accepted.
module cache_ctrl_2way
    import cache_pkg::*;
#(
    parameter int TAG_WIDTH  = TAG_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int SET_WIDTH  = SET_WIDTH_DEF,
    parameter int ADDR_WIDTH = TAG_WIDTH + SET_WIDTH
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_hit,
    input  logic                  flush,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_resp_data,
    output logic                  way_enable_read,
    output logic [SET_WIDTH-1:0]  way_set_index,
    output logic [TAG_WIDTH-1:0]  way_tag_in,
    output logic [DATA_WIDTH-1:0] way_data_in,
    output logic                  way0_we_tag,
    output logic                  way0_we_data,
    output logic                  way1_we_tag,
    output logic                  way1_we_data,
    input  logic [TAG_WIDTH-1:0]  way0_tag_out,
    input  logic [TAG_WIDTH-1:0]  way1_tag_out,
    input  logic [DATA_WIDTH-1:0] way0_data_out,
    input  logic [DATA_WIDTH-1:0] way1_data_out
);

    ctrl_state_t           state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  victim_q, victim_d;
    logic                  accept;
    logic [31:0]           hit_cnt, miss_cnt;
    logic                  hit_evt, miss_evt;

    logic [SET_WIDTH-1:0]  set_q, req_set;
    logic [TAG_WIDTH-1:0]  tag_q;

    logic                  v0, v1, lru_bit;
    logic                  hit0, hit1, miss_victim;
    logic                  clear_all, upd_en, fill_en, fill_way, lru_way;

    assign set_q   = SET_WIDTH'(addr_set(32'(addr_q), SET_WIDTH));
    assign tag_q   = TAG_WIDTH'(addr_tag(32'(addr_q), SET_WIDTH));
    assign req_set = SET_WIDTH'(addr_set(32'(req_addr), SET_WIDTH));

    cache_set_state #(
        .SET_WIDTH (SET_WIDTH)
    ) u_set_state (
        .clk       (clk),
        .resetn    (resetn),
        .clear_all (clear_all),
        .rd_set    (set_q),
        .rd_valid0 (v0),
        .rd_valid1 (v1),
        .rd_lru    (lru_bit),
        .upd_en    (upd_en),
        .upd_set   (set_q),
        .fill_en   (fill_en),
        .fill_way  (fill_way),
        .lru_way   (lru_way)
    );

    // Way 0 wins a double hit; misses prefer an empty way before evicting the LRU one.
    assign hit0        = v0 && (way0_tag_out == tag_q);
    assign hit1        = v1 && (way1_tag_out == tag_q);
    assign miss_victim = !v0 ? 1'b0 : (!v1 ? 1'b1 : lru_bit);

    assign mem_req_addr = addr_q;

    always_comb begin
        state_d         = state_q;
        victim_d        = victim_q;
        accept          = 1'b0;
        req_ready       = 1'b0;
        resp_valid      = 1'b0;
        resp_hit        = 1'b0;
        resp_data       = '0;
        mem_req_valid   = 1'b0;
        way_enable_read = 1'b0;
        way_set_index   = set_q;
        way_tag_in      = tag_q;
        way_data_in     = mem_resp_data;
        way0_we_tag     = 1'b0;
        way0_we_data    = 1'b0;
        way1_we_tag     = 1'b0;
        way1_we_data    = 1'b0;
        clear_all       = 1'b0;
        upd_en          = 1'b0;
        fill_en         = 1'b0;
        fill_way        = victim_q;
        lru_way         = 1'b0;
        hit_evt         = 1'b0;
        miss_evt        = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready     = !flush;
                way_set_index = req_set;
                if (flush) begin
                    clear_all = 1'b1;
                end else if (req_valid) begin
                    accept          = 1'b1;
                    way_enable_read = 1'b1;
                    state_d         = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit0 || hit1) begin
                    resp_valid = 1'b1;
                    resp_hit   = 1'b1;
                    resp_data  = hit0 ? way0_data_out : way1_data_out;
                    upd_en     = 1'b1;
                    lru_way    = hit0;
                    hit_evt    = 1'b1;
                    state_d    = IDLE;
                end else begin
                    victim_d = miss_victim;
                    miss_evt = 1'b1;
                    state_d  = MISS_REQ;
                end
            end
            MISS_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) state_d = MISS_WAIT;
            end
            MISS_WAIT: begin
                if (mem_resp_valid) begin
                    way0_we_tag  = !victim_q;
                    way0_we_data = !victim_q;
                    way1_we_tag  = victim_q;
                    way1_we_data = victim_q;
                    upd_en       = 1'b1;
                    fill_en      = 1'b1;
                    lru_way      = !victim_q;
                    resp_valid   = 1'b1;
                    resp_data    = mem_resp_data;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            victim_q <= 1'b0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
            if (accept)   addr_q   <= req_addr;
            if (hit_evt)  hit_cnt  <= hit_cnt + 32'd1;
            if (miss_evt) miss_cnt <= miss_cnt + 32'd1;
        end
    end

    // Debug counters have no port; they are probed hierarchically.
    logic unused_dbg;
    assign unused_dbg = ^{hit_cnt, miss_cnt};

endmodule

// File: tb/tb_cache_ctrl_2way.sv
// Randomized bench: two behavioural BRAM ways, a responding backing memory,
// and a per-set line model predicting hit/miss, victim and returned data.
module tb_cache_ctrl_2way;

    localparam int TW = 13;
    localparam int DW = 16;
    localparam int SW = 8;
    localparam int AW = TW + SW;
    localparam int NS = 1 << SW;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          req_valid = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic          flush = 1'b0;
    logic          mem_req_ready = 1'b0;
    logic          mem_resp_valid = 1'b0;
    logic [DW-1:0] mem_resp_data = '0;

    logic          req_ready, resp_valid, resp_hit, mem_req_valid, way_enable_read;
    logic [DW-1:0] resp_data, way_data_in;
    logic [AW-1:0] mem_req_addr;
    logic [SW-1:0] way_set_index;
    logic [TW-1:0] way_tag_in;
    logic          way0_we_tag, way0_we_data, way1_we_tag, way1_we_data;
    logic [TW-1:0] way0_tag_out, way1_tag_out;
    logic [DW-1:0] way0_data_out, way1_data_out;

    logic [TW-1:0] m_tag [2][NS];
    logic [DW-1:0] m_data[2][NS];

    bit            rv[2][NS];
    logic [TW-1:0] rt[2][NS];
    logic [DW-1:0] rd[2][NS];
    bit            rl[NS];

    int n_checks = 0;
    int n_fail   = 0;

    cache_ctrl_2way dut (
        .clk             (clk),
        .resetn          (resetn),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_addr        (req_addr),
        .resp_valid      (resp_valid),
        .resp_data       (resp_data),
        .resp_hit        (resp_hit),
        .flush           (flush),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_req_addr    (mem_req_addr),
        .mem_resp_valid  (mem_resp_valid),
        .mem_resp_data   (mem_resp_data),
        .way_enable_read (way_enable_read),
        .way_set_index   (way_set_index),
        .way_tag_in      (way_tag_in),
        .way_data_in     (way_data_in),
        .way0_we_tag     (way0_we_tag),
        .way0_we_data    (way0_we_data),
        .way1_we_tag     (way1_we_tag),
        .way1_we_data    (way1_we_data),
        .way0_tag_out    (way0_tag_out),
        .way1_tag_out    (way1_tag_out),
        .way0_data_out   (way0_data_out),
        .way1_data_out   (way1_data_out)
    );

    always #5 clk = ~clk;

    // BRAM ways: registered read, data appears the cycle after the enable.
    always @(posedge clk) begin
        if (way_enable_read) begin
            way0_tag_out  <= m_tag[0][way_set_index];
            way1_tag_out  <= m_tag[1][way_set_index];
            way0_data_out <= m_data[0][way_set_index];
            way1_data_out <= m_data[1][way_set_index];
        end
        if (way0_we_tag)  m_tag[0][way_set_index]  <= way_tag_in;
        if (way0_we_data) m_data[0][way_set_index] <= way_data_in;
        if (way1_we_tag)  m_tag[1][way_set_index]  <= way_tag_in;
        if (way1_we_data) m_data[1][way_set_index] <= way_data_in;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] memval(input logic [AW-1:0] a);
        logic [AW-1:0] p;
        p = a * 21'd40503;
        return DW'(p) ^ 16'h3C5A;
    endfunction

    task automatic model_clear_valid();
        for (int s = 0; s < NS; s++) begin
            rv[0][s] = 1'b0;
            rv[1][s] = 1'b0;
        end
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(negedge clk);
        check("flush_rdy", req_ready, 0);
        tick();
        flush = 1'b0;
        model_clear_valid();
    endtask

    // One read transaction; the bench plays backing memory with given delays.
    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] fill,
                           input int rdy_wait, input int rsp_wait,
                           output int way_w, output bit was_hit);
        int            s;
        int            v;
        logic [TW-1:0] t;
        bit            h0, h1;
        s  = int'(a[SW-1:0]);
        t  = a[AW-1:SW];
        h0 = rv[0][s] && (rt[0][s] == t);
        h1 = rv[1][s] && (rt[1][s] == t);
        way_w = -1;
        req_valid = 1'b1;
        req_addr  = a;
        @(negedge clk);
        check("req_ready", req_ready, 1);
        check("rd_en", way_enable_read, 1);
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        was_hit = resp_valid && resp_hit;
        if (h0 || h1) begin
            v = h0 ? 0 : 1;
            check("hit_vld", resp_valid, 1);
            check("hit_flag", resp_hit, 1);
            check("hit_data", resp_data, rd[v][s]);
            check("hit_nomem", mem_req_valid, 0);
            rl[s] = (v == 0);
            tick();
        end else begin
            v = !rv[0][s] ? 0 : (!rv[1][s] ? 1 : int'(rl[s]));
            check("miss_noresp", resp_valid, 0);
            tick();
            for (int i = 0; i < rdy_wait; i++) begin
                @(negedge clk);
                check("mreq_hold_vld", mem_req_valid, 1);
                check("mreq_hold_addr", mem_req_addr, a);
                check("mreq_hold_noresp", resp_valid, 0);
                tick();
            end
            mem_req_ready = 1'b1;
            @(negedge clk);
            check("mreq_vld", mem_req_valid, 1);
            check("mreq_addr", mem_req_addr, a);
            tick();
            mem_req_ready = 1'b0;
            for (int i = 0; i < rsp_wait; i++) begin
                @(negedge clk);
                check("mwait_noresp", resp_valid, 0);
                check("mwait_noreq", mem_req_valid, 0);
                tick();
            end
            mem_resp_valid = 1'b1;
            mem_resp_data  = fill;
            @(negedge clk);
            check("fill_vld", resp_valid, 1);
            check("fill_flag", resp_hit, 0);
            check("fill_data", resp_data, fill);
            check("fill_set", way_set_index, s);
            check("fill_tag", way_tag_in, t);
            check("fill_wdat", way_data_in, fill);
            if (way0_we_tag && way0_we_data && !way1_we_tag && !way1_we_data) way_w = 0;
            else if (way1_we_tag && way1_we_data && !way0_we_tag && !way0_we_data) way_w = 1;
            check("fill_way", way_w, v);
            tick();
            mem_resp_valid = 1'b0;
            rv[v][s] = 1'b1;
            rt[v][s] = t;
            rd[v][s] = fill;
            rl[s]    = (v == 0);
        end
    endtask

    initial begin
        int            w;
        bit            h;
        logic [AW-1:0] a;

        for (int i = 0; i < NS; i++) begin
            m_tag[0][i]  <= TW'($urandom);
            m_tag[1][i]  <= TW'($urandom);
            m_data[0][i] <= DW'($urandom);
            m_data[1][i] <= DW'($urandom);
            rv[0][i] = 1'b0;
            rv[1][i] = 1'b0;
            rl[i]    = 1'b0;
        end
        repeat (3) tick();
        resetn = 1'b1;
        @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_hit", resp_hit, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_mreq_valid", mem_req_valid, 0);
        check("rst_mreq_addr", mem_req_addr, 0);
        check("rst_rd_en", way_enable_read, 0);
        check("rst_we", {way0_we_tag, way0_we_data, way1_we_tag, way1_we_data}, 0);
        tick();

        // First touch of 0x00105 misses into way0, then hits.
        do_read(21'h00105, 16'hBEEF, 0, 1, w, h);
        check("t1_miss", h, 0);
        check("t1_way0", w, 0);
        do_read(21'h00105, 16'h0000, 0, 0, w, h);
        check("t2_hit", h, 1);

        // Tag 2 fills way1; tag 1 refreshed; tag 3 evicts way1 (LRU).
        do_read(21'h00205, 16'h2222, 1, 0, w, h);
        check("t3_way1", w, 1);
        do_read(21'h00105, 16'h0000, 0, 0, w, h);
        check("t3_tag1_hit", h, 1);
        do_read(21'h00305, 16'h3333, 0, 2, w, h);
        check("t3_evict_w1", w, 1);
        do_read(21'h00105, 16'h0000, 0, 0, w, h);
        check("t3_tag1_still", h, 1);
        do_read(21'h00205, 16'h2223, 0, 0, w, h);
        check("t3_tag2_gone", h, 0);

        // flush together with req_valid: flush wins, no acceptance.
        flush     = 1'b1;
        req_valid = 1'b1;
        req_addr  = 21'h00105;
        @(negedge clk);
        check("fl_req_ready", req_ready, 0);
        check("fl_rd_en", way_enable_read, 0);
        tick();
        flush     = 1'b0;
        req_valid = 1'b0;
        model_clear_valid();
        @(negedge clk);
        check("fl_not_accepted", req_ready, 1);
        tick();
        do_read(21'h00105, 16'h4444, 0, 0, w, h);
        check("fl_miss", h, 0);

        // Memory holds off the request for 5 cycles.
        do_read(21'h00777, memval(21'h00777), 5, 1, w, h);
        check("stall_miss", h, 0);

        // Reset during MISS_WAIT; the late memory response must be ignored.
        req_valid = 1'b1;
        req_addr  = 21'h00A33;
        tick();
        req_valid = 1'b0;
        tick();
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        @(negedge clk);
        check("mw_noreq", mem_req_valid, 0);
        tick();
        resetn = 1'b0;
        tick();
        resetn         = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 16'h5555;
        @(negedge clk);
        check("rstmw_noresp", resp_valid, 0);
        check("rstmw_nowe", {way0_we_tag, way0_we_data, way1_we_tag, way1_we_data}, 0);
        check("rstmw_ready", req_ready, 1);
        tick();
        mem_resp_valid = 1'b0;
        model_clear_valid();
        for (int i = 0; i < NS; i++) rl[i] = 1'b0;
        do_read(21'h00A33, 16'h6666, 0, 0, w, h);
        check("rstmw_remiss", h, 0);
        do_read(21'h00105, 16'h7777, 0, 0, w, h);
        check("rst_cleared_hit", h, 0);

        // Randomized traffic over a small tag/set footprint to force conflicts.
        do_flush();
        for (int n = 0; n < 300; n++) begin
            a = {TW'($urandom_range(0, 5)), SW'($urandom_range(0, 3))};
            if ($urandom_range(0, 9) == 0) begin
                do_flush();
            end else begin
                do_read(a, memval(a), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), w, h);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_ctrl_2way.md
Name: cache_ctrl_2way

Overview:
- Read-side controller that drives two cache_way instances as a 2-way set-associative, one-word-per-line, read-only cache.
- Accepts word-addressed read requests from the core and performs tag lookup through the ways' BRAM ports.
- On a miss it fetches from backing memory over a valid/ready request channel, then fills the chosen victim way.
- Owns per-set valid and LRU state, which the ways do not store.

Parameters:
TAG_WIDTH, 13, tag bits per line (matches cache_way)
DATA_WIDTH, 16, word width
SET_WIDTH, 8, set index bits; 2^SET_WIDTH sets
ADDR_WIDTH, TAG_WIDTH+SET_WIDTH, request address width; addr = {tag, set}

Ports:
clk  in  1  clock, rising edge
resetn  in  1  synchronous active-low reset
req_valid  in  1  core read request
req_ready  out  1  controller can accept request
req_addr  in  ADDR_WIDTH  word address
resp_valid  out  1  one-cycle response pulse
resp_data  out  DATA_WIDTH  read data, valid with resp_valid
resp_hit  out  1  1 = served from cache, 0 = served by fill
flush  in  1  invalidate all lines (pulse)
mem_req_valid  out  1  backing-memory read request
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  ADDR_WIDTH  miss address
mem_resp_valid  in  1  memory read data valid
mem_resp_data  in  DATA_WIDTH  memory read data
way_enable_read  out  1  read enable to both ways
way_set_index  out  SET_WIDTH  set index to both ways
way_tag_in  out  TAG_WIDTH  fill tag to both ways
way_data_in  out  DATA_WIDTH  fill data to both ways
way0_we_tag, way0_we_data, way1_we_tag, way1_we_data  out  1 each  per-way write enables
way0_tag_out, way1_tag_out  in  TAG_WIDTH  way tag read data
way0_data_out, way1_data_out  in  DATA_WIDTH  way data read data

Behaviour:
- Way reads have 1-cycle latency: data appears the cycle after way_enable_read.
- Reset (resetn=0 at clk edge):
  - state=IDLE; all valid bits and LRU bits cleared.
  - req_ready=1, resp_valid=0, resp_hit=0, resp_data=0, mem_req_valid=0, mem_req_addr=0.
  - All way write enables and way_enable_read are 0.
  - Reset mid-miss abandons the request; a later mem_resp_valid in IDLE is ignored.
- IDLE:
  - req_ready=1 unless flush=1.
  - flush=1: clear all valid bits this cycle; a simultaneous req_valid is not accepted.
  - Otherwise on req_valid: latch req_addr, drive way_enable_read=1 and way_set_index=set; go to LOOKUP.
- LOOKUP (req_ready=0):
  - hitN = valid[N][set] && (wayN_tag_out == tag). If both hit, way0 wins.
  - Hit: resp_valid=1, resp_hit=1, resp_data=hit way data; LRU[set] := other way; go to IDLE. Hit latency is 2 cycles from acceptance.
  - Miss victim selection, in order: first invalid way (way0 before way1), else way LRU[set]. Latch victim; go to MISS_REQ.
- MISS_REQ:
  - mem_req_valid=1 and mem_req_addr=latched address, both held stable until mem_req_ready.
  - On handshake go to MISS_WAIT.
- MISS_WAIT:
  - On mem_resp_valid, same cycle:
    - victim we_tag=we_data=1, with way_set_index, way_tag_in=tag, way_data_in=mem_resp_data.
    - valid[victim][set]:=1; LRU[set]:=other way.
    - resp_valid=1, resp_hit=0, resp_data=mem_resp_data.
    - Go to IDLE.
- flush outside IDLE is ignored; the caller holds it until req_ready.
- Back-to-back requests: a new request can be accepted the cycle after resp_valid. No pipelining of lookups.
- Counters hit_cnt and miss_cnt (32-bit, internal, wrap) are kept for debug. They are cleared on reset and not cleared by flush.

Decomposition:
- cache_pkg:
  - ctrl_state_t enum {IDLE, LOOKUP, MISS_REQ, MISS_WAIT}
  - tag/set extraction functions
  - default width constants
- Sub-module cache_set_state: valid[2] and LRU bit arrays, with clear-all, per-set read, and update ports.

Test Plan:
- Reset, then read 0x00105 -> miss; mem_req_addr=0x00105; return 0xBEEF -> resp_data=0xBEEF, resp_hit=0; way0 written at set 0x05.
- Re-read 0x00105 -> resp_hit=1, resp_data=0xBEEF, 2 cycles after acceptance, no mem request.
- Fill tags 1, 2, 3 into set 0x05 (reading tag 1 in between) -> tag 3 evicts way1 (tag 2, the LRU way); tag 1 still hits.
- flush pulse, then read 0x00105 -> miss, new mem request. Also: flush and req_valid in the same cycle -> request not accepted.
- Hold mem_req_ready=0 for 5 cycles -> mem_req_valid and mem_req_addr stable throughout; no resp_valid.
- Assert resetn=0 during MISS_WAIT, then deliver mem_resp_valid -> ignored; next read of the same address misses.
